// File: rtl/mc_ctrl_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_fsm_pkg
// Purpose  : Shared opcodes, Exec op encodings and FSM types for mc_ctrl_fsm.
// Revision : 1.0
// ============================================================================
package mc_ctrl_fsm_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Low four bits of alu_op; the MSB picks arithmetic (0) or control (1)
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] BR_BEQ   = 4'b0000;
    localparam logic [3:0] BR_BNE   = 4'b0001;
    localparam logic [3:0] BR_BLT   = 4'b0100;
    localparam logic [3:0] BR_BGE   = 4'b0101;
    localparam logic [3:0] BR_BLTU  = 4'b0110;
    localparam logic [3:0] BR_BGEU  = 4'b0111;
    localparam logic [3:0] CTL_JAL  = 4'b1011;
    localparam logic [3:0] CTL_JALR = 4'b1001;
    localparam logic [3:0] CTL_LUI  = 4'b1000;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    localparam logic [1:0] PC_SRC_PC4    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd2;

    localparam logic [1:0] WB_SEL_ALUOUT = 2'd0;
    localparam logic [1:0] WB_SEL_MDR    = 2'd1;
    localparam logic [1:0] WB_SEL_PC4    = 2'd2;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_fsm_alu_op_decode.sv
`default_nettype none
// ============================================================================
// Module   : mc_alu_op_decode
// Purpose  : Combinational instr -> Exec op code, immediate format, legality.
// Revision : 1.0
// ============================================================================
module mc_alu_op_decode
    import mc_ctrl_fsm_pkg::*;
#(
    parameter int ALU_CTRL_WIDTH = 5
) (
    input  logic [31:0]               instr,
    output logic [ALU_CTRL_WIDTH-1:0] alu_op,
    output logic [2:0]                imm_type,
    output logic                      illegal
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_op_ctl;
    logic [3:0] w_op_code;
    logic       w_unused_fields;

    assign w_opcode        = instr[6:0];
    assign w_funct3        = instr[14:12];
    assign w_funct7        = instr[31:25];
    assign w_unused_fields = ^{instr[24:15], instr[11:7]};

    always_comb begin
        w_op_ctl  = 1'b0;
        w_op_code = ALU_ADD;
        imm_type  = IMM_I;
        illegal   = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_op_code = {w_funct7[5], w_funct3};
                if (w_funct7 != 7'b0000000 && w_funct7 != 7'b0100000)
                    illegal = 1'b1;
                else if (w_funct7[5] && w_funct3 != 3'b000 && w_funct3 != 3'b101)
                    illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                // Only SRAI borrows funct7[5]; ADDI's imm[10] must not turn it into SUB
                w_op_code = {(w_funct3 == 3'b101) & w_funct7[5], w_funct3};
                if (w_funct3 == 3'b001 && w_funct7 != 7'b0000000)
                    illegal = 1'b1;
                if (w_funct3 == 3'b101 && w_funct7 != 7'b0000000 && w_funct7 != 7'b0100000)
                    illegal = 1'b1;
            end
            OPC_LOAD: begin
                if (w_funct3 == 3'b011 || w_funct3 == 3'b110 || w_funct3 == 3'b111)
                    illegal = 1'b1;
            end
            OPC_STORE: begin
                imm_type = IMM_S;
                if (w_funct3 >= 3'b011)
                    illegal = 1'b1;
            end
            OPC_AUIPC: imm_type = IMM_U;
            OPC_LUI: begin
                imm_type  = IMM_U;
                w_op_ctl  = 1'b1;
                w_op_code = CTL_LUI;
            end
            OPC_JAL: begin
                imm_type  = IMM_J;
                w_op_ctl  = 1'b1;
                w_op_code = CTL_JAL;
            end
            OPC_JALR: begin
                w_op_ctl  = 1'b1;
                w_op_code = CTL_JALR;
            end
            OPC_BRANCH: begin
                imm_type  = IMM_B;
                w_op_ctl  = 1'b1;
                w_op_code = {1'b0, w_funct3};
                if (w_funct3 == 3'b010 || w_funct3 == 3'b011)
                    illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        alu_op                   = '0;
        alu_op[ALU_CTRL_WIDTH-1] = w_op_ctl;
        alu_op[3:0]              = w_op_code;
    end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_fsm
// Purpose  : Multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB).
// Revision : 1.0
// ============================================================================
module mc_ctrl_fsm
    import mc_ctrl_fsm_pkg::*;
#(
    parameter int ALU_CTRL_WIDTH = 5,
    parameter int MEM_TIMEOUT    = 0,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [31:0]               instr,
    input  logic                      bcond,
    input  logic                      mem_ready,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic                      mem_addr_sel,
    output logic                      ir_write,
    output logic                      mdr_write,
    output logic                      pc_write,
    output logic [1:0]                pc_src,
    output logic [ALU_CTRL_WIDTH-1:0] alu_op,
    output logic                      alu_src1_sel,
    output logic                      alu_src2_sel,
    output logic                      aluout_write,
    output logic [2:0]                imm_type,
    output logic                      reg_write,
    output logic [1:0]                wb_sel,
    output logic                      illegal,
    output logic                      bus_err,
    output logic [CNT_WIDTH-1:0]      instret
);

    state_t                    r_state;
    state_t                    w_next;
    logic [CNT_WIDTH-1:0]      r_instret;
    logic                      r_illegal;
    logic                      r_bus_err;
    logic                      w_retire;
    logic                      w_timeout;
    logic [ALU_CTRL_WIDTH-1:0] w_dec_alu_op;
    logic [2:0]                w_dec_imm;
    logic                      w_dec_illegal;
    logic                      w_is_branch, w_is_load, w_is_store, w_is_jump;
    logic                      w_src1_pc, w_src2_rs2;

    mc_alu_op_decode #(
        .ALU_CTRL_WIDTH (ALU_CTRL_WIDTH)
    ) u_decode (
        .instr    (instr),
        .alu_op   (w_dec_alu_op),
        .imm_type (w_dec_imm),
        .illegal  (w_dec_illegal)
    );

    assign w_is_branch = (instr[6:0] == OPC_BRANCH);
    assign w_is_load   = (instr[6:0] == OPC_LOAD);
    assign w_is_store  = (instr[6:0] == OPC_STORE);
    assign w_is_jump   = (instr[6:0] == OPC_JAL) || (instr[6:0] == OPC_JALR);
    assign w_src1_pc   = (instr[6:0] == OPC_AUIPC) || (instr[6:0] == OPC_JAL);
    assign w_src2_rs2  = (instr[6:0] == OPC_OP) || w_is_branch;

    generate
        if (MEM_TIMEOUT > 0) begin : g_timeout
            localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
            logic [WAIT_W-1:0] r_wait_cnt;
            logic              w_in_req;

            assign w_in_req = (r_state == ST_FETCH) || (r_state == ST_MEM);

            // Cleared on every handshake so MEM -> FETCH starts a fresh count
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_wait_cnt <= '0;
                else if (w_in_req && !mem_ready)
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                else
                    r_wait_cnt <= '0;
            end

            assign w_timeout = w_in_req && !mem_ready &&
                               (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_INIT;
            r_instret <= '0;
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_retire)
                r_instret <= r_instret + 1'b1;
            if (r_state == ST_DECODE && w_dec_illegal)
                r_illegal <= 1'b1;
            if (w_timeout)
                r_bus_err <= 1'b1;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_retire     = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        mdr_write    = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_SRC_PC4;
        alu_op       = '0;
        alu_src1_sel = 1'b0;
        alu_src2_sel = 1'b0;
        aluout_write = 1'b0;
        imm_type     = IMM_I;
        reg_write    = 1'b0;
        wb_sel       = WB_SEL_ALUOUT;
        case (r_state)
            ST_INIT: w_next = ST_FETCH;
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    w_next   = ST_DECODE;
                end else if (w_timeout) begin
                    w_next = ST_TRAP;
                end
            end
            ST_DECODE: begin
                imm_type = w_dec_imm;
                w_next   = w_dec_illegal ? ST_TRAP : ST_EXEC;
            end
            ST_EXEC: begin
                alu_op       = w_dec_alu_op;
                alu_src1_sel = w_src1_pc;
                alu_src2_sel = !w_src2_rs2;
                if (w_is_branch) begin
                    pc_write = 1'b1;
                    pc_src   = bcond ? PC_SRC_BRANCH : PC_SRC_PC4;
                    w_retire = 1'b1;
                    w_next   = ST_FETCH;
                end else begin
                    aluout_write = 1'b1;
                    w_next       = (w_is_load || w_is_store) ? ST_MEM : ST_WB;
                end
            end
            ST_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = w_is_store;
                if (mem_ready) begin
                    if (w_is_store) begin
                        pc_write = 1'b1;
                        w_retire = 1'b1;
                        w_next   = ST_FETCH;
                    end else begin
                        mdr_write = 1'b1;
                        w_next    = ST_WB;
                    end
                end else if (w_timeout) begin
                    w_next = ST_TRAP;
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                wb_sel    = w_is_load ? WB_SEL_MDR : (w_is_jump ? WB_SEL_PC4 : WB_SEL_ALUOUT);
                pc_write  = 1'b1;
                pc_src    = w_is_jump ? PC_SRC_ALUOUT : PC_SRC_PC4;
                w_retire  = 1'b1;
                w_next    = ST_FETCH;
            end
            default: w_next = ST_TRAP;
        endcase
    end

    assign instret = r_instret;
    assign illegal = r_illegal;
    assign bus_err = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl_fsm
// Purpose  : Directed cycle-by-cycle bench for mc_ctrl_fsm.
// Revision : 1.0
// ============================================================================
module tb_mc_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        bcond;
    logic        mem_ready;
    logic        mem_req, mem_we, mem_addr_sel, ir_write, mdr_write, pc_write;
    logic [1:0]  pc_src;
    logic [4:0]  alu_op;
    logic        alu_src1_sel, alu_src2_sel, aluout_write;
    logic [2:0]  imm_type;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        illegal, bus_err;
    logic [31:0] instret;

    int n_vec = 0;
    int n_err = 0;
    int exp_ret = 0;

    typedef struct packed {
        logic       mem_req, mem_we, mem_addr_sel, ir_write, mdr_write, pc_write;
        logic [1:0] pc_src;
        logic [4:0] alu_op;
        logic       src1, src2, aluout_write;
        logic [2:0] imm_type;
        logic       reg_write;
        logic [1:0] wb_sel;
    } strb_t;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(
        .ALU_CTRL_WIDTH (5),
        .MEM_TIMEOUT    (4),
        .CNT_WIDTH      (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr        (instr),
        .bcond        (bcond),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_write     (ir_write),
        .mdr_write    (mdr_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .alu_op       (alu_op),
        .alu_src1_sel (alu_src1_sel),
        .alu_src2_sel (alu_src2_sel),
        .aluout_write (aluout_write),
        .imm_type     (imm_type),
        .reg_write    (reg_write),
        .wb_sel       (wb_sel),
        .illegal      (illegal),
        .bus_err      (bus_err),
        .instret      (instret)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic strb_t cur();
        strb_t s;
        s.mem_req = mem_req;        s.mem_we = mem_we;          s.mem_addr_sel = mem_addr_sel;
        s.ir_write = ir_write;      s.mdr_write = mdr_write;    s.pc_write = pc_write;
        s.pc_src = pc_src;          s.alu_op = alu_op;          s.src1 = alu_src1_sel;
        s.src2 = alu_src2_sel;      s.aluout_write = aluout_write;
        s.imm_type = imm_type;      s.reg_write = reg_write;    s.wb_sel = wb_sel;
        return s;
    endfunction

    function automatic strb_t e_fetch(input logic rdy);
        strb_t e = '0;
        e.mem_req = 1'b1; e.ir_write = rdy;
        return e;
    endfunction

    function automatic strb_t e_dec(input logic [2:0] imm);
        strb_t e = '0;
        e.imm_type = imm;
        return e;
    endfunction

    function automatic strb_t e_exec(input logic [4:0] op, input logic s1, input logic s2,
                                     input logic aw, input logic pcw, input logic [1:0] pcs);
        strb_t e = '0;
        e.alu_op = op; e.src1 = s1; e.src2 = s2; e.aluout_write = aw;
        e.pc_write = pcw; e.pc_src = pcs;
        return e;
    endfunction

    function automatic strb_t e_mem(input logic we, input logic rdy, input logic ld);
        strb_t e = '0;
        e.mem_req = 1'b1; e.mem_addr_sel = 1'b1; e.mem_we = we;
        e.mdr_write = rdy & ld; e.pc_write = rdy & ~ld;
        return e;
    endfunction

    function automatic strb_t e_wb(input logic [1:0] wbs, input logic [1:0] pcs);
        strb_t e = '0;
        e.reg_write = 1'b1; e.wb_sel = wbs; e.pc_write = 1'b1; e.pc_src = pcs;
        return e;
    endfunction

    // Check one cycle at the falling edge, then advance to just past the next rising edge
    task automatic step(input string tag, input strb_t exp);
        @(negedge clk);
        chk(tag, cur(), exp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        exp_ret = 0;
        step("reset.init", '0);
    endtask

    task automatic run_alu(input string tag, input logic [31:0] ins, input logic [2:0] imm,
                           input logic [4:0] op, input logic s1, input logic s2,
                           input logic [1:0] wbs, input logic [1:0] pcs);
        instr = ins; mem_ready = 1'b1; bcond = 1'b0;
        step({tag, ".fetch"}, e_fetch(1'b1));
        step({tag, ".decode"}, e_dec(imm));
        step({tag, ".exec"}, e_exec(op, s1, s2, 1'b1, 1'b0, 2'd0));
        step({tag, ".wb"}, e_wb(wbs, pcs));
        exp_ret++;
        chk({tag, ".instret"}, instret, exp_ret);
    endtask

    task automatic run_br(input string tag, input logic [31:0] ins, input logic bc);
        instr = ins; mem_ready = 1'b1; bcond = bc;
        step({tag, ".fetch"}, e_fetch(1'b1));
        step({tag, ".decode"}, e_dec(3'd2));
        step({tag, ".exec"}, e_exec(5'b1_0001, 1'b0, 1'b0, 1'b0, 1'b1, bc ? 2'd1 : 2'd0));
        exp_ret++;
        chk({tag, ".instret"}, instret, exp_ret);
    endtask

    logic [31:0] bad_ops [7] = '{32'h0000_007F, 32'h0220_81B3, 32'h4020_C1B3, 32'h0020_A463,
                                 32'h0040_B303, 32'h0020_B423, 32'h4032_9293};

    initial begin
        rst_n = 1'b0; instr = 32'h0020_81B3; bcond = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("reset.strobes", cur(), '0);
        chk("reset.instret", instret, 32'd0);
        chk("reset.flags", {illegal, bus_err}, 2'b00);
        rst_n = 1'b1;
        step("init", '0);

        run_alu("add",   32'h0020_81B3, 3'd0, 5'b0_0000, 1'b0, 1'b0, 2'd0, 2'd0);
        run_alu("sub",   32'h4020_81B3, 3'd0, 5'b0_1000, 1'b0, 1'b0, 2'd0, 2'd0);
        run_alu("srai",  32'h4032_D293, 3'd0, 5'b0_1101, 1'b0, 1'b1, 2'd0, 2'd0);
        run_alu("srli",  32'h0032_D293, 3'd0, 5'b0_0101, 1'b0, 1'b1, 2'd0, 2'd0);
        run_br("bne_t",  32'h0020_9463, 1'b1);
        run_br("bne_nt", 32'h0020_9463, 1'b0);

        // LW with two wait cycles in both FETCH and MEM: nine cycles in total
        instr = 32'h0040_A303; bcond = 1'b0; mem_ready = 1'b0;
        step("lw.fetch0", e_fetch(1'b0));
        step("lw.fetch1", e_fetch(1'b0));
        mem_ready = 1'b1;
        step("lw.fetch2", e_fetch(1'b1));
        step("lw.decode", e_dec(3'd0));
        step("lw.exec", e_exec(5'b0_0000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0));
        mem_ready = 1'b0;
        step("lw.mem0", e_mem(1'b0, 1'b0, 1'b1));
        step("lw.mem1", e_mem(1'b0, 1'b0, 1'b1));
        mem_ready = 1'b1;
        step("lw.mem2", e_mem(1'b0, 1'b1, 1'b1));
        step("lw.wb", e_wb(2'd1, 2'd0));
        exp_ret++;
        chk("lw.instret", instret, exp_ret);

        instr = 32'h0020_A423;
        step("sw.fetch", e_fetch(1'b1));
        step("sw.decode", e_dec(3'd1));
        step("sw.exec", e_exec(5'b0_0000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0));
        step("sw.mem", e_mem(1'b1, 1'b1, 1'b0));
        exp_ret++;
        chk("sw.instret", instret, exp_ret);

        run_alu("jalr",  32'h0002_80E7, 3'd0, 5'b1_1001, 1'b0, 1'b1, 2'd2, 2'd2);
        run_alu("jal",   32'h0080_00EF, 3'd4, 5'b1_1011, 1'b1, 1'b1, 2'd2, 2'd2);
        run_alu("lui",   32'h1234_52B7, 3'd3, 5'b1_1000, 1'b0, 1'b1, 2'd0, 2'd0);
        run_alu("auipc", 32'h0000_1517, 3'd3, 5'b0_0000, 1'b1, 1'b1, 2'd0, 2'd0);

        // Asynchronous reset while a load waits in MEM
        instr = 32'h0040_A303; mem_ready = 1'b1;
        step("rst.fetch", e_fetch(1'b1));
        step("rst.decode", e_dec(3'd0));
        step("rst.exec", e_exec(5'b0_0000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0));
        mem_ready = 1'b0;
        #1;
        chk("rst.mem_req_before", mem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst.strobes_async", cur(), '0);
        chk("rst.instret_async", instret, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; exp_ret = 0;
        step("rst.init", '0);
        mem_ready = 1'b1; instr = 32'h0020_81B3;
        step("rst.fetch_after", e_fetch(1'b1));

        foreach (bad_ops[i]) begin
            do_reset();
            instr = bad_ops[i]; mem_ready = 1'b1;
            step($sformatf("ill%0d.fetch", i), e_fetch(1'b1));
            @(posedge clk);
            #1;
            step($sformatf("ill%0d.trap", i), '0);
            chk($sformatf("ill%0d.flags", i), {illegal, bus_err}, 2'b10);
        end
        step("ill.trap_hold", '0);
        chk("ill.instret", instret, 32'd0);

        do_reset();
        instr = 32'h0020_81B3; mem_ready = 1'b0;
        for (int c = 0; c < 4; c++)
            step($sformatf("to.fetch%0d", c), e_fetch(1'b0));
        chk("to.flags_at_trap", {illegal, bus_err}, 2'b01);
        step("to.trap", '0);
        mem_ready = 1'b1;
        step("to.trap_hold", '0);
        chk("to.flags_held", {illegal, bus_err}, 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle control unit for the RV32I core.
- Sequences FETCH/DECODE/EXEC/MEM/WB and drives the Exec ALU through a 5-bit operation code and operand selects.
- Consumes the ALU's bcond for branch resolution.
- Drives the datapath strobes for PC, IR, ALUOut, register file and the unified memory request/ready handshake.

Parameters:
- ALU_CTRL_WIDTH, 5, width of alu_op. MSB=1 selects branch/JAL/JALR/LUI; MSB=0 selects arithmetic.
- MEM_TIMEOUT, 0, maximum cycles to wait for mem_ready. 0 disables the timeout.
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock; all state changes on the rising edge
- rst_n  in  1  asynchronous active-low reset
- instr  in  32  IR contents; stable from DECODE onward
- bcond  in  1  branch condition from Exec
- mem_ready  in  1  memory accepted/completed the current request
- mem_req  out  1  memory request
- mem_we  out  1  store when 1, read when 0
- mem_addr_sel  out  1  0=PC, 1=ALUOut
- ir_write  out  1  latch instr from memory read data
- mdr_write  out  1  latch load data
- pc_write  out  1  update PC
- pc_src  out  2  0=PC+4, 1=branch target (external PC+imm adder), 2=ALUOut
- alu_op  out  ALU_CTRL_WIDTH  Exec operation code
- alu_src1_sel  out  1  0=rs1, 1=PC
- alu_src2_sel  out  1  0=rs2, 1=imm
- aluout_write  out  1  latch Exec Out into ALUOut
- imm_type  out  3  0=I, 1=S, 2=B, 3=U, 4=J
- reg_write  out  1  register file write (x0 suppressed in the regfile)
- wb_sel  out  2  0=ALUOut, 1=MDR, 2=PC+4
- illegal  out  1  sticky: illegal instruction trapped
- bus_err  out  1  sticky: memory timeout trapped
- instret  out  CNT_WIDTH  retired-instruction count

Behaviour:
- Reset (async, rst_n=0):
  - state=INIT, instret=0, illegal=0, bus_err=0.
  - All strobes 0; alu_op=0_0000.
  - Strobes are decoded from registered state, so they are 0 throughout reset.
- INIT: one cycle with all outputs idle, then FETCH.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr_sel=0 every cycle until mem_ready=1.
  - In the mem_ready cycle: ir_write=1, next state DECODE.
- DECODE: one cycle.
  - Classifies the opcode and drives imm_type.
  - Illegal encodings go to TRAP with illegal=1:
    - unknown opcode;
    - R-type funct7 other than 0000000/0100000, or 0100000 with funct3 not 000/101;
    - SLLI/SRLI/SRAI with bad funct7;
    - branch funct3 010/011;
    - load funct3 011/110/111;
    - store funct3 >= 011.
- EXEC: one cycle; aluout_write=1 except for branches.
  - R/I arithmetic: alu_op={0, funct7[5] (R-type, or I-type SRAI only), funct3}. ADDI ignores imm bit 10.
  - Load/store/AUIPC: alu_op=0_0000.
    - src1: rs1 for load/store; PC for AUIPC.
    - src2: imm.
  - LUI: alu_op=1_1000, src2=imm.
  - JAL: alu_op=1_1011, src1=PC, src2=imm.
  - JALR: alu_op=1_1001, src1=rs1, src2=imm.
  - Branch:
    - alu_op={1,0,funct3[2:0]} with src rs1/rs2.
    - pc_write=1; pc_src=1 if bcond else 0.
    - instret+1, next state FETCH.
  - Load/store go to MEM; all others go to WB.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we=1 for store, held until mem_ready=1.
  - Store: pc_write=1 with pc_src=0, instret+1, next state FETCH.
  - Load: mdr_write=1, next state WB.
- WB:
  - reg_write=1.
  - wb_sel: 1 for load, 2 for JAL/JALR, else 0.
  - pc_write=1; pc_src=2 for JAL/JALR, else 0.
  - instret+1, next state FETCH.
- Latency with zero-wait memory:
  - branch 3 cycles;
  - store and ALU/LUI/AUIPC/JAL/JALR 4 cycles;
  - load 5 cycles.
  - Each wait cycle adds 1.
- alu_op outside EXEC is 0_0000. Select outputs outside their active state are 0.
- Timeout (MEM_TIMEOUT>0):
  - A wait counter clears on entry to FETCH/MEM.
  - If mem_ready has not arrived after MEM_TIMEOUT request cycles: deassert mem_req, go to TRAP with bus_err=1.
- TRAP: all strobes 0, flags held; leaves only on reset.
- instret wraps modulo 2^CNT_WIDTH.
- Reset mid-operation aborts immediately. No partial PC or register write survives, because strobes drop asynchronously with state.

Decomposition:
- Shared package contents:
  - opcode constants;
  - the ALU/branch/JAL/JALR/LUI op encodings shared with Exec (ADD 0000, SUB 1000, XOR 0100, OR 0110, AND 0111, SLT 0010, SLTU 0011, SLL 0001, SRL 0101, SRA 1101, BEQ 0000, BNE 0001, BLT 0100, BGE 0101, BLTU 0110, BGEU 0111, JAL 1011, JALR 1001, LUI 1000);
  - state encoding;
  - pc_src, wb_sel and imm_type constants.
- One combinational sub-module, mc_alu_op_decode: instr to alu_op, imm_type and illegal.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), mem_ready always 1:
  - FETCH, DECODE, EXEC, WB.
  - EXEC alu_op=0_0000, aluout_write=1.
  - WB reg_write=1, wb_sel=0, pc_write=1, pc_src=0, instret 0→1.
- SUB and SRAI x5,x5,3 (0x4032D293): EXEC alu_op=0_1000 and 0_1101. SRLI gives 0_0101.
- BNE with bcond=1, then bcond=0:
  - 3 cycles each; alu_op=1_0001.
  - pc_src=1 for the taken branch, 0 for the not-taken branch.
  - reg_write never asserted.
- LW with mem_ready delayed 2 cycles in both FETCH and MEM:
  - 9 cycles total; mdr_write in the ready cycle.
  - WB wb_sel=1.
- JALR: EXEC alu_op=1_1001, src1=0, src2=1. WB wb_sel=2, pc_src=2.
- Illegal opcode 0x0000007F → TRAP with illegal=1 and all strobes 0. MEM_TIMEOUT=4 with mem_ready held 0 in FETCH → bus_err=1 after 4 cycles. rst_n pulsed low mid-MEM → all strobes 0 and instret=0 immediately, then INIT, then FETCH.
